// File: rtl/uart_tx_mmio_if.sv
// Store-bus view of the UART transmitter: the core's store strobe, address and
// data going in, and the polled status word coming back.
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] stat;

  modport master (output we, a, wd, input stat);
  modport slave  (input we, a, wd, output stat);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR fill a byte FIFO that
// is serialized on txd. STAT_ADDR exposes FIFO/FSM status and clears overflow.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          DEPTH        = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0800,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0804
) (
  input  logic           sysclk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           txd,
  output logic           busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [15:0]     RELOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full, empty;
  logic          push_req, push_ok, ovf_clr, pop;

  state_t        state, state_d;
  logic [15:0]   baud, baud_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          txd_d;

  // Upper store-data bits carry nothing for this block.
  logic          unused_wd;
  assign unused_wd = ^bus.wd[31:8];

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = bus.we && (bus.a == TX_ADDR);
  assign ovf_clr  = bus.we && (bus.a == STAT_ADDR) && bus.wd[3];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  assign busy     = (state != IDLE);
  assign bus.stat = {17'd0, 7'(count), 4'd0, ovf, busy, empty, full};

  // NOTE: payload storage has no reset; emptiness is carried by count and the pointers.
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= bus.wd[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A rejected push wins over a clear in the same cycle.
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_d;
      baud  <= baud_d;
      idx   <= idx_d;
      shift <= shift_d;
      txd   <= txd_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    idx_d   = idx;
    shift_d = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_d  = RELOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          shift_d = shift >> 1;
          idx_d   = idx + 3'd1;
          baud_d  = RELOAD;
          if (idx == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            baud_d  = RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered: derive the level the line takes in the next state.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's store bus, in parallel with `mem`. It captures CPU stores to a fixed TX address into a byte FIFO and serializes each byte as 8N1 on `txd`. It also exposes a status word that software polls before writing. Addresses decoded here lie outside the 512-word RAM, so `mem` needs no change.

## Interface
- `CLKS_PER_BIT`, default 868: `sysclk` cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `DEPTH`, default 8: FIFO depth in bytes; power of two, 2..64.
- `TX_ADDR`, default 32'h0000_0800: store address that pushes a byte.
- `STAT_ADDR`, default 32'h0000_0804: status register address (read and write).
- `sysclk`, in, 1: system clock, single clock domain.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset asserted).
- `we`, in, 1: store strobe, the core's `memwrite`.
- `a`, in, 32: byte address, the core's `adr`.
- `wd`, in, 32: store data, the core's `writedata`.
- `stat`, out, 32: combinational status word.
- `txd`, out, 1: serial output, idles high.
- `busy`, out, 1: 1 while the FSM is outside IDLE.

## Operation
- Address decode uses `a` exactly, with no masking.
  - `we & a==TX_ADDR` is a push request. `wd[7:0]` is the byte; `wd[31:8]` is ignored.
  - `we & a==STAT_ADDR & wd[3]` clears the sticky `ovf` flag.
- FIFO: circular buffer, `DEPTH` entries. Read and write pointers are `log2(DEPTH)` bits and wrap naturally. Count is `log2(DEPTH)+1` bits.
- Push is accepted if `count<DEPTH`, or if a pop occurs in the same cycle.
- A rejected push leaves the FIFO unchanged and sets `ovf`.
- If a push is rejected in the same cycle as an `ovf` clear, `ovf` ends set.
- Status word `stat`:
  - bit0 `full` (count==DEPTH)
  - bit1 `empty` (count==0)
  - bit2 `busy`
  - bit3 `ovf`
  - bits[14:8] `count`
  - all other bits 0
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd=1`. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with `CLKS_PER_BIT-1`, and go to START.
  - START: `txd=0`. When the baud counter reaches 0, reload it, set bit index to 0, and go to DATA.
  - DATA: `txd=shift[0]`, LSB first. At counter 0, shift right, increment the index, and reload. After index 7 completes, go to STOP.
  - STOP: `txd=1`. At counter 0:
    - FIFO non-empty: pop, reload, go directly to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
- `txd` is registered; it is never driven from combinational logic.

## Timing
- Reset values: `txd=1`, `busy=0`, FIFO empty, `ovf=0`, state IDLE, so `stat=32'h0000_0002`.
- Reset mid-frame aborts the frame immediately and flushes the FIFO. `txd` returns to 1 asynchronously.
- A push at edge N is visible in `stat.count` after edge N.
- Latency with the FSM in IDLE:
  - The pop occurs at edge N+1.
  - `txd` falls and `busy` rises after edge N+1.
  - `busy` covers 10×`CLKS_PER_BIT` cycles per frame.
- Each bit (start, 8 data, stop) is held exactly `CLKS_PER_BIT` cycles.
- For back-to-back frames, the next start bit begins the cycle after the previous stop bit's last cycle.
- In the multi-cycle core a store occupies one cycle (MEMWR), so each store yields exactly one push. A level `we` held k cycles yields k pushes; the block does not edge-detect.
- `stat` is combinational from registers. When polled, it is sampled like `mem` read data.

## Test plan
- Reset release, idle: hold `reset=0` then release with no stores -> `stat`=32'h0000_0002, `txd`=1, `busy`=0 for 100 cycles.
- Single byte, framing: `CLKS_PER_BIT=4`, store 32'hFFFF_FFA5 to 0x800 ->
  - `txd` sequence (4 cycles each): 0,1,0,1,0,0,1,0,1,1
  - the `wd[31:8]` bits are ignored
  - `busy` high for exactly 40 cycles, then `stat`=0x2
- Back-to-back frames: push 0x00 then 0xFF on consecutive cycles -> 20 bit periods with no idle gap; the second start bit immediately follows the first stop bit.
- Full and overflow:
  - `DEPTH=4`, `CLKS_PER_BIT=100`; push 6 bytes in 6 cycles -> 1 popped immediately, 4 buffered, 6th rejected.
  - `stat` = full=1, count=4, ovf=1.
  - Store 0x8 to 0x804 -> ovf=0.
  - The transmitted bytes are the first five in order.
- Simultaneous push and pop at full: FIFO full while STOP ends and a push arrives in the same cycle -> push accepted, count stays DEPTH, `ovf` stays 0.
- Reset mid-frame: assert `reset=0` during DATA bit 3 -> `txd`=1 and `busy`=0 immediately. After release, `stat`=0x2 and no residual frame is sent.
